// File: rtl/fc_argmax_2.sv
// Argmax over the PO-lane output-neuron RAMs of the second FC layer.
// Scans every bank address once and reports the winning class index and its signed value.
module fc_argmax_2 #(
    parameter int DATA_WIDTH_FC           = 16,
    parameter int PO                      = 2,
    parameter int OUTNEURON               = 10,
    parameter int FC_OUTNEURON_ADDR_WIDTH = 4,
    parameter int CLASS_ID_WIDTH          = 4,
    parameter int READ_LATENCY            = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic [DATA_WIDTH_FC*PO-1:0]        out_neuron_q_a_all,
    output logic [FC_OUTNEURON_ADDR_WIDTH-1:0] out_neuron_addra,
    output logic                               out_neuron_rden_a,
    output logic                               busy,
    output logic                               done,
    output logic [CLASS_ID_WIDTH-1:0]          class_id,
    output logic [DATA_WIDTH_FC-1:0]           max_value
);

    localparam int DEPTH = (OUTNEURON + PO - 1) / PO;
    localparam logic [FC_OUTNEURON_ADDR_WIDTH-1:0] LAST_ADDR = FC_OUTNEURON_ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                             state;
    logic                               first;
    logic [READ_LATENCY-1:0]            pipe_v;
    logic [FC_OUTNEURON_ADDR_WIDTH-1:0] pipe_a [READ_LATENCY];

    logic                               word_any;
    logic [DATA_WIDTH_FC-1:0]           word_max;
    logic [CLASS_ID_WIDTH-1:0]          word_idx;
    logic [DATA_WIDTH_FC-1:0]           lane_val;
    int                                 lane_n;

    // Strict compare while walking lanes upward keeps the lowest lane on ties.
    always_comb begin
        word_any = 1'b0;
        word_max = '0;
        word_idx = '0;
        lane_val = '0;
        lane_n   = 0;
        for (int unsigned p = 0; p < PO; p++) begin
            lane_val = out_neuron_q_a_all[p*DATA_WIDTH_FC +: DATA_WIDTH_FC];
            lane_n   = int'(pipe_a[READ_LATENCY-1]) * PO + int'(p);
            if (lane_n < OUTNEURON &&
                (!word_any || $signed(lane_val) > $signed(word_max))) begin
                word_any = 1'b1;
                word_max = lane_val;
                word_idx = CLASS_ID_WIDTH'(lane_n);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            first             <= 1'b0;
            pipe_v            <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) pipe_a[i] <= '0;
            out_neuron_addra  <= '0;
            out_neuron_rden_a <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            class_id          <= '0;
            max_value         <= '0;
        end else begin
            pipe_v[0] <= out_neuron_rden_a;
            pipe_a[0] <= out_neuron_addra;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end

            if (pipe_v[READ_LATENCY-1] && word_any &&
                (first || $signed(word_max) > $signed(max_value))) begin
                max_value <= word_max;
                class_id  <= word_idx;
                first     <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state             <= S_READ;
                        busy              <= 1'b1;
                        first             <= 1'b1;
                        out_neuron_addra  <= '0;
                        out_neuron_rden_a <= 1'b1;
                    end
                end
                S_READ: begin
                    if (out_neuron_addra == LAST_ADDR) begin
                        state             <= S_DRAIN;
                        out_neuron_rden_a <= 1'b0;
                        out_neuron_addra  <= '0;
                    end else begin
                        out_neuron_addra <= out_neuron_addra + 1'b1;
                    end
                end
                // Leave once the last issued address reaches the compare stage.
                S_DRAIN: begin
                    if (pipe_v[READ_LATENCY-1] && pipe_a[READ_LATENCY-1] == LAST_ADDR) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_argmax_2.sv
// Directed bench for fc_argmax_2: three instances cover the default build,
// a masked last word (OUTNEURON=9) and a two-cycle RAM read latency.
module tb_fc_argmax_2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v = '0;
    logic [31:0] q_v [3];
    logic [3:0]  addr_v [3];
    logic [2:0]  rden_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [3:0]  cid_v [3];
    logic [15:0] max_v [3];

    logic [15:0] mem0 [10];
    logic [15:0] mem1 [10];
    logic [15:0] mem2 [10];
    logic [31:0] q2_stage;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fc_argmax_2 dut0 (
        .clock(clk), .reset(rst_n), .start(start_v[0]), .out_neuron_q_a_all(q_v[0]),
        .out_neuron_addra(addr_v[0]), .out_neuron_rden_a(rden_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .class_id(cid_v[0]), .max_value(max_v[0])
    );

    fc_argmax_2 #(.OUTNEURON(9)) dut1 (
        .clock(clk), .reset(rst_n), .start(start_v[1]), .out_neuron_q_a_all(q_v[1]),
        .out_neuron_addra(addr_v[1]), .out_neuron_rden_a(rden_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .class_id(cid_v[1]), .max_value(max_v[1])
    );

    fc_argmax_2 #(.READ_LATENCY(2)) dut2 (
        .clock(clk), .reset(rst_n), .start(start_v[2]), .out_neuron_q_a_all(q_v[2]),
        .out_neuron_addra(addr_v[2]), .out_neuron_rden_a(rden_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .class_id(cid_v[2]), .max_value(max_v[2])
    );

    // Bank p at address k holds neuron k*2+p; q registers on a read and holds otherwise.
    always @(posedge clk) begin
        if (rden_v[0]) q_v[0] <= {mem0[int'(addr_v[0])*2+1], mem0[int'(addr_v[0])*2]};
        if (rden_v[1]) q_v[1] <= {mem1[int'(addr_v[1])*2+1], mem1[int'(addr_v[1])*2]};
        if (rden_v[2]) q2_stage <= {mem2[int'(addr_v[2])*2+1], mem2[int'(addr_v[2])*2]};
        q_v[2] <= q2_stage;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic scan(input int d, input string tag, input int exp_done,
                        input int exp_cid, input logic [15:0] exp_max, input bit extra);
        int done_cnt = 0;
        int done_at = -1;
        int addr_err = 0;
        @(negedge clk);
        start_v[d] = 1'b1;
        for (int j = 1; j <= exp_done + 5; j++) begin
            @(negedge clk);
            start_v[d] = extra && (j == 2 || j == 3 || j == exp_done);
            if (j <= 5) begin
                if (!rden_v[d] || addr_v[d] != 4'(j - 1)) addr_err++;
            end else if (rden_v[d] || addr_v[d] != 4'd0) begin
                addr_err++;
            end
            if (j == 1) check({tag, "_busy"}, 32'(busy_v[d]), 32'd1);
            if (done_v[d]) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
                check({tag, "_busy_at_done"}, 32'(busy_v[d]), 32'd0);
            end
        end
        start_v[d] = 1'b0;
        check({tag, "_addr_seq"}, 32'(addr_err), 32'd0);
        check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_class_id"}, 32'(cid_v[d]), 32'(exp_cid));
        check({tag, "_max_value"}, 32'(max_v[d]), 32'(exp_max));
    endtask

    int basic [10] = '{3, -5, 7, 2, 100, 9, -1, 0, 50, 4};
    int negs  [10] = '{-200, -200, -200, -200, -200, -200, -200, -200, -200, -3};
    int ties  [10] = '{0, 0, 77, 0, 0, 0, 0, 0, 77, 0};
    int maskd [10] = '{1, -2, 3, 4, 5, 0, 20, 7, 8, 1000};

    initial begin
        int dcnt;
        for (int i = 0; i < 10; i++) begin
            mem0[i] = 16'(basic[i]);
            mem1[i] = 16'(maskd[i]);
            mem2[i] = 16'(basic[i]);
        end
        ties[3] = 77;
        q_v[0] = '0; q_v[1] = '0; q_v[2] = '0; q2_stage = '0;

        #12;
        check("rst_addr", 32'(addr_v[0]), 32'd0);
        check("rst_rden", 32'(rden_v[0]), 32'd0);
        check("rst_busy", 32'(busy_v[0]), 32'd0);
        check("rst_done", 32'(done_v[0]), 32'd0);
        check("rst_class_id", 32'(cid_v[0]), 32'd0);
        check("rst_max_value", 32'(max_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        scan(0, "basic", 7, 4, 16'd100, 1'b0);

        for (int i = 0; i < 10; i++) mem0[i] = 16'(negs[i]);
        scan(0, "allneg", 7, 9, 16'hFFFD, 1'b0);

        for (int i = 0; i < 10; i++) mem0[i] = 16'(ties[i]);
        scan(0, "ties", 7, 2, 16'd77, 1'b0);

        scan(1, "mask", 7, 6, 16'd20, 1'b0);

        scan(2, "lat2", 8, 4, 16'd100, 1'b1);

        // Abort a scan with reset on its third cycle.
        for (int i = 0; i < 10; i++) mem0[i] = 16'(basic[i]);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_addr", 32'(addr_v[0]), 32'd0);
        check("abort_rden", 32'(rden_v[0]), 32'd0);
        check("abort_busy", 32'(busy_v[0]), 32'd0);
        check("abort_done", 32'(done_v[0]), 32'd0);
        check("abort_class_id", 32'(cid_v[0]), 32'd0);
        check("abort_max_value", 32'(max_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (done_v[0]) dcnt++;
        end
        check("abort_no_done", 32'(dcnt), 32'd0);

        for (int i = 0; i < 10; i++) mem0[i] = 16'(negs[i]);
        scan(0, "after_abort", 7, 9, 16'hFFFD, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/fc_argmax_2.md
Name: fc_argmax_2

Overview:
- Classifier stage directly downstream of the second fully-connected layer.
- After the FC layer finishes writing its PO output-neuron RAM banks, this block reads every bank in parallel through port A and finds the neuron with the largest signed activation.
- It reports that neuron's class index and value, and pulses done.
- It owns port A read control of the output-neuron RAMs for the duration of a scan.

Parameters:
- DATA_WIDTH_FC, 16: signed width of one output neuron.
- PO, 2: number of parallel output-neuron RAM banks (lanes).
- OUTNEURON, 10: number of valid output neurons (classes).
- FC_OUTNEURON_ADDR_WIDTH, 4: bank address width.
- CLASS_ID_WIDTH, 4: width of class index; must satisfy 2^CLASS_ID_WIDTH >= OUTNEURON.
- READ_LATENCY, 1: cycles from address/rden to valid q (1 or 2).

Ports:
- clock, input, 1: single clock; all logic on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse that begins a scan; ignored while busy.
- out_neuron_q_a_all, input, DATA_WIDTH_FC*PO: concatenated bank outputs; lane p occupies bits [p*DATA_WIDTH_FC +: DATA_WIDTH_FC].
- out_neuron_addra, output, FC_OUTNEURON_ADDR_WIDTH: common read address to all banks.
- out_neuron_rden_a, output, 1: read enable to all banks.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle pulse when the result is valid.
- class_id, output, CLASS_ID_WIDTH: index of the winning neuron.
- max_value, output, DATA_WIDTH_FC: signed value of the winning neuron.

Behaviour:
- Reset (async, reset=0): state IDLE. All outputs 0: addr, rden, busy, done, class_id, max_value. Pipeline valid bits cleared. Reset mid-scan aborts with no done pulse.
- Mapping: DEPTH = ceil(OUTNEURON/PO). Bank p at address k holds neuron n = k*PO + p. Lanes with n >= OUTNEURON in the last word are masked and never win.
- FSM:
  - IDLE: start=1 -> READ, busy=1, addr=0, rden=1.
  - READ: one address per cycle, 0..DEPTH-1, rden=1. After issuing DEPTH-1 -> DRAIN, rden=0.
  - DRAIN: wait until the last read word has been compared (READ_LATENCY cycles) -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Issue tracking: a READ_LATENCY-deep shift register carries {valid, address} alongside each read, so q is sampled exactly READ_LATENCY cycles after its address was driven.
- Per-word reduction (combinational):
  - Signed compare across unmasked lanes; ties resolve to the lowest lane.
  - Yields word_max and word_idx = k*PO + lane.
- Running update (registered):
  - The first valid word of a scan loads unconditionally.
  - Later words replace the running result only if word_max > running max (strict). Ties therefore keep the lowest neuron index.
- class_id and max_value update only through the running registers. They hold their value from done until the next start updates them.
- Timing: with start sampled high at cycle 0, addresses are driven in cycles 1..DEPTH and done is high at cycle DEPTH+READ_LATENCY+1.
- start during busy or DONE is ignored; no queuing.
- Arithmetic: comparisons are signed two's complement, full DATA_WIDTH_FC. No saturation or bias.
- out_neuron_addra returns to 0 and rden to 0 outside READ.

Test Plan:
- Basic scan, PO=2, OUTNEURON=10, READ_LATENCY=1:
  - Stimulus: neurons 0..9 = {3,-5,7,2,100,9,-1,0,50,4}.
  - Required: addresses 0..4 driven on cycles 1..5, done on cycle 7, class_id=4, max_value=100.
- All negative:
  - Stimulus: all neurons -200 except neuron 9 = -3.
  - Required: class_id=9, max_value=-3 (0xFFFD). Proves signed compare.
- Ties:
  - Stimulus: neurons 2, 3 and 8 all = 77, others 0.
  - Required: class_id=2 (intra-word lane tie and inter-word tie both keep the lowest index).
- Masking, OUTNEURON=9, PO=2:
  - Stimulus: lane 1 at address 4 (phantom neuron 9) = 1000; real max is neuron 6 = 20.
  - Required: class_id=6, max_value=20, DEPTH=5.
- READ_LATENCY=2 with start pulses during busy:
  - Stimulus: same data as the basic scan; extra start pulses while busy.
  - Required: done on cycle 8, exactly one done pulse, result unchanged.
- Reset mid-scan:
  - Stimulus: assert reset=0 on cycle 3 of a scan, release, then issue a new start.
  - Required: outputs 0 immediately after reset and no done for the aborted scan. The new scan completes with the correct class_id.
